// File: rtl/writeback_stage.sv
// Writeback stage: W pipeline register, load-data alignment/extension, load-wait FSM and retire counter.
// LoadStallW and ResultW are combinational from the W register and the data-memory read port.
module writeback_stage #(
    parameter int XLEN = 32,
    parameter int CNTW = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic [2:0]      ResultSrcM,
    input  logic [2:0]      Funct3M,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] ImmExtM,
    input  logic [XLEN-1:0] CSRDataM,
    input  logic            StallW,
    input  logic            FlushW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic            ReadValidW,
    output logic            RegWriteW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ResultW,
    output logic            LoadStallW,
    output logic [CNTW-1:0] InstRetW
);
    localparam int OFFW = $clog2(XLEN/8);
    localparam logic [2:0] SRC_ALU  = 3'b000;
    localparam logic [2:0] SRC_LOAD = 3'b001;
    localparam logic [2:0] SRC_PC4  = 3'b010;
    localparam logic [2:0] SRC_IMM  = 3'b011;
    localparam logic [2:0] SRC_CSR  = 3'b100;

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic              valid_q, regwrite_q;
    logic [2:0]        src_q, funct3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   alu_q, pc4_q, imm_q, csr_q;
    logic [CNTW-1:0]   inst_q, inst_d;
    logic              w_load, commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            src_q      <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            csr_q      <= '0;
        end else if (!LoadStallW && !StallW) begin
            if (FlushW) begin
                valid_q <= 1'b0;
            end else begin
                valid_q    <= ValidM;
                regwrite_q <= RegWriteM;
                src_q      <= ResultSrcM;
                funct3_q   <= Funct3M;
                rd_q       <= RdM;
                alu_q      <= ALUResultM;
                pc4_q      <= PCPlus4M;
                imm_q      <= ImmExtM;
                csr_q      <= CSRDataM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
        end
    end

    assign w_load = valid_q && (src_q == SRC_LOAD);

    // A load whose data arrives in its first W cycle never stalls.
    always_comb begin
        state_d    = state_q;
        LoadStallW = 1'b0;
        case (state_q)
            S_RUN: begin
                if (w_load && !ReadValidW) begin
                    LoadStallW = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_load) begin
                    state_d = S_RUN;
                end else if (!ReadValidW) begin
                    LoadStallW = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    assign commit    = valid_q && !LoadStallW;
    assign inst_d    = commit ? inst_q + CNTW'(1) : inst_q;
    assign InstRetW  = inst_q;
    assign RegWriteW = commit && regwrite_q && (rd_q != 5'd0);
    assign RdW       = rd_q;

    // Load extraction: shift the addressed lane down, then extend in 64 bits and trim to XLEN.
    logic [OFFW+2:0] sh_b, sh_h, sh_w;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     word_v;
    logic [XLEN-1:0] load_val;

    assign sh_b   = {alu_q[OFFW-1:0], 3'b000};
    assign sh_h   = sh_b & ~((OFFW+3)'(15));
    assign sh_w   = sh_b & ~((OFFW+3)'(31));
    assign byte_v = 8'(ReadDataW >> sh_b);
    assign half_v = 16'(ReadDataW >> sh_h);
    assign word_v = 32'(ReadDataW >> sh_w);

    always_comb begin
        load_val = ReadDataW;
        case (funct3_q)
            3'b000: load_val = XLEN'({{56{byte_v[7]}}, byte_v});
            3'b001: load_val = XLEN'({{48{half_v[15]}}, half_v});
            3'b010: load_val = XLEN'({{32{word_v[31]}}, word_v});
            3'b100: load_val = XLEN'({56'd0, byte_v});
            3'b101: load_val = XLEN'({48'd0, half_v});
            3'b110: load_val = (XLEN == 64) ? XLEN'({32'd0, word_v}) : ReadDataW;
            default: load_val = ReadDataW;
        endcase
    end

    always_comb begin
        ResultW = '0;
        case (src_q)
            SRC_ALU:  ResultW = alu_q;
            SRC_LOAD: ResultW = load_val;
            SRC_PC4:  ResultW = pc4_q;
            SRC_IMM:  ResultW = imm_q;
            SRC_CSR:  ResultW = csr_q;
            default:  ResultW = '0;
        endcase
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed cases on 32- and 64-bit instances, then a randomized scoreboard run.
module tb_writeback_stage;
    logic        clk, rst_n;
    logic        v_m, rw_m, stall_w, flush_w, rvalid_w;
    logic [2:0]  src_m, f3_m;
    logic [4:0]  rd_m;
    logic [63:0] alu_m, pc4_m, imm_m, csr_m, rdata_w;

    logic        rw32, ls32, rw64, ls64;
    logic [4:0]  rdw32, rdw64;
    logic [31:0] res32;
    logic [63:0] res64, iret32;
    logic [3:0]  iret64;

    int checks = 0;
    int errors = 0;

    writeback_stage #(.XLEN(32), .CNTW(64)) u32 (
        .clk(clk), .rst_n(rst_n), .ValidM(v_m), .RegWriteM(rw_m), .ResultSrcM(src_m),
        .Funct3M(f3_m), .RdM(rd_m), .ALUResultM(alu_m[31:0]), .PCPlus4M(pc4_m[31:0]),
        .ImmExtM(imm_m[31:0]), .CSRDataM(csr_m[31:0]), .StallW(stall_w), .FlushW(flush_w),
        .ReadDataW(rdata_w[31:0]), .ReadValidW(rvalid_w), .RegWriteW(rw32), .RdW(rdw32),
        .ResultW(res32), .LoadStallW(ls32), .InstRetW(iret32));

    writeback_stage #(.XLEN(64), .CNTW(4)) u64 (
        .clk(clk), .rst_n(rst_n), .ValidM(v_m), .RegWriteM(rw_m), .ResultSrcM(src_m),
        .Funct3M(f3_m), .RdM(rd_m), .ALUResultM(alu_m), .PCPlus4M(pc4_m),
        .ImmExtM(imm_m), .CSRDataM(csr_m), .StallW(stall_w), .FlushW(flush_w),
        .ReadDataW(rdata_w), .ReadValidW(rvalid_w), .RegWriteW(rw64), .RdW(rdw64),
        .ResultW(res64), .LoadStallW(ls64), .InstRetW(iret64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        vld, rw;
        bit [2:0]  src, f3;
        bit [4:0]  rd;
        bit [31:0] alu, pc4, imm, csr, data;
        int        lat;
    } inst_t;

    typedef struct {
        bit        rw;
        bit [4:0]  rd;
        bit [31:0] res;
    } commit_t;

    commit_t cq[$];
    bit      sq[$];
    bit      mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] extract32(input bit [31:0] d, input bit [1:0] off, input bit [2:0] f3);
        bit [7:0]  b;
        bit [15:0] h;
        b = 8'(d >> (8 * int'(off)));
        h = 16'(d >> (16 * int'(off[1])));
        case (f3)
            3'd0: return {{24{b[7]}}, b};
            3'd1: return {{16{h[15]}}, h};
            3'd4: return {24'd0, b};
            3'd5: return {16'd0, h};
            default: return d;
        endcase
    endfunction

    function automatic bit [31:0] exp_result(input inst_t i);
        case (i.src)
            3'd0: return i.alu;
            3'd1: return extract32(i.data, i.alu[1:0], i.f3);
            3'd2: return i.pc4;
            3'd3: return i.imm;
            3'd4: return i.csr;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input bit rw, input bit [2:0] src, input bit [2:0] f3,
                         input bit [4:0] rd, input bit [63:0] alu);
        v_m = v; rw_m = rw; src_m = src; f3_m = f3; rd_m = rd; alu_m = alu;
        pc4_m = 64'h1004; imm_m = 64'h2000; csr_m = 64'h3000;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        issue(0, 0, 0, 0, 0, 0);
        stall_w = 0; flush_w = 0; rvalid_w = 0; rdata_w = 0;
        #1;
        chk("reset_regwrite", rw32, 0);
        chk("reset_rd", rdw32, 0);
        chk("reset_result", res32, 0);
        chk("reset_loadstall", ls32, 0);
        chk("reset_instret", iret32, 0);
        chk("reset_instret64", iret64, 0);
        step;
        step;
        rst_n = 1'b1;
        step;
    endtask

    // Scoreboard monitor: an InstRetW step between two falling edges marks the earlier sample as a commit.
    bit        prev_rw, have_prev;
    bit [4:0]  prev_rd;
    bit [31:0] prev_res;
    bit [63:0] prev_cnt;
    commit_t   mc;

    always @(negedge clk) begin
        if (mon_en) begin
            if (have_prev) begin
                if (iret32 == prev_cnt + 64'd1) begin
                    if (cq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_commit actual=%h required=%h", iret32, prev_cnt);
                    end else begin
                        mc = cq.pop_front();
                        chk("commit_regwrite", prev_rw, mc.rw);
                        chk("commit_rd", prev_rd, mc.rd);
                        chk("commit_result", prev_res, mc.res);
                    end
                end else begin
                    chk("idle_instret", iret32, prev_cnt);
                    chk("idle_regwrite", prev_rw, 0);
                end
            end
            if (sq.size() == 0) begin
                checks++; errors++;
                $display("FAIL stall_queue_empty actual=%h required=expectation", ls32);
            end else begin
                chk("load_stall", ls32, sq.pop_front());
            end
            prev_rw = rw32; prev_rd = rdw32; prev_res = res32; prev_cnt = iret32;
            have_prev = 1'b1;
        end else begin
            have_prev = 1'b0;
        end
    end

    inst_t cur, nx;
    int    exp_cnt;

    initial begin
        // 64-bit lane selection and 4-bit counter wrap
        do_reset;
        issue(1, 1, 3'd1, 3'b010, 5'd10, 64'h4);
        step;
        rvalid_w = 1; rdata_w = 64'h80000000_12345678;
        issue(1, 1, 3'd1, 3'b110, 5'd11, 64'h4);
        #1 chk("lw64_result", res64, 64'hFFFFFFFF_80000000);
        chk("lw64_loadstall", ls64, 0);
        step;
        issue(1, 1, 3'd1, 3'b011, 5'd12, 64'h0);
        chk("lwu64_result", res64, 64'h00000000_80000000);
        step;
        issue(1, 1, 3'd1, 3'b001, 5'd13, 64'h6);
        chk("ld64_result", res64, 64'h80000000_12345678);
        step;
        issue(1, 1, 3'd0, 3'b000, 5'd1, 64'h42);
        chk("lh64_result", res64, 64'hFFFFFFFF_FFFF8000);
        for (int k = 0; k < 12; k++) step;
        chk("instret64_15", iret64, 4'd15);
        issue(0, 0, 0, 0, 0, 0);
        step;
        chk("instret64_wrap", iret64, 4'd0);

        // ALU commit
        do_reset;
        issue(1, 1, 3'd0, 3'd0, 5'd5, 64'h1234);
        step;
        chk("alu_regwrite", rw32, 1);
        chk("alu_rd", rdw32, 5);
        chk("alu_result", res32, 32'h1234);
        chk("alu_instret_before", iret32, 0);
        issue(0, 0, 0, 0, 0, 0);
        step;
        chk("alu_instret_after", iret32, 1);
        chk("idle_regwrite", rw32, 0);

        // zero-wait LB / LBU at byte offset 3
        rvalid_w = 1; rdata_w = 64'h80FF0000;
        issue(1, 1, 3'd1, 3'b000, 5'd3, 64'h103);
        step;
        issue(1, 1, 3'd1, 3'b100, 5'd4, 64'h103);
        chk("lb_result", res32, 32'hFFFFFF80);
        chk("lb_loadstall", ls32, 0);
        chk("lb_regwrite", rw32, 1);
        step;
        chk("lbu_result", res32, 32'h00000080);
        issue(0, 0, 0, 0, 0, 0);
        step;
        chk("lb_instret", iret32, 3);

        // late load: three wait cycles with a younger instruction held in M
        rvalid_w = 0;
        issue(1, 1, 3'd1, 3'b010, 5'd7, 64'h200);
        step;
        issue(1, 1, 3'd0, 3'd0, 5'd9, 64'h55);
        for (int k = 0; k < 3; k++) begin
            chk("late_loadstall", ls32, 1);
            chk("late_regwrite", rw32, 0);
            chk("late_instret", iret32, 3);
            chk("late_rd", rdw32, 7);
            step;
        end
        rvalid_w = 1; rdata_w = 64'hDEADBEEF;
        #1;
        chk("late_release_stall", ls32, 0);
        chk("late_commit_regwrite", rw32, 1);
        chk("late_commit_result", res32, 32'hDEADBEEF);
        step;
        rvalid_w = 0;
        chk("after_late_rd", rdw32, 9);
        chk("after_late_result", res32, 32'h55);
        chk("after_late_instret", iret32, 4);
        issue(0, 0, 0, 0, 0, 0);
        step;
        chk("after_late_instret2", iret32, 5);

        // x0 destination and flush bubble
        issue(1, 1, 3'd0, 3'd0, 5'd0, 64'h77);
        step;
        chk("x0_regwrite", rw32, 0);
        issue(1, 1, 3'd0, 3'd0, 5'd6, 64'h88);
        flush_w = 1;
        step;
        chk("x0_instret", iret32, 6);
        chk("flush_regwrite", rw32, 0);
        flush_w = 0;
        issue(0, 0, 0, 0, 0, 0);
        step;
        chk("flush_instret", iret32, 6);

        // reset while waiting for load data
        issue(1, 1, 3'd1, 3'b010, 5'd8, 64'h0);
        step;
        issue(0, 0, 0, 0, 0, 0);
        step;
        chk("wait_loadstall", ls32, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midwait_reset_regwrite", rw32, 0);
        chk("midwait_reset_rd", rdw32, 0);
        chk("midwait_reset_result", res32, 0);
        chk("midwait_reset_stall", ls32, 0);
        chk("midwait_reset_instret", iret32, 0);
        step;
        rst_n = 1'b1;
        rvalid_w = 1; rdata_w = 64'h12345678;
        step;
        chk("stray_regwrite", rw32, 0);
        chk("stray_loadstall", ls32, 0);
        step;
        chk("stray_instret", iret32, 0);

        // randomized run against the instruction-level model
        do_reset;
        cur = '{default: 0};
        exp_cnt = 0;
        mon_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            bit stalled, tail;
            int r;
            tail = (n >= 390);
            stalled = 0;
            if (cur.vld && cur.src == 3'd1) begin
                if (cur.lat > 0) begin
                    rvalid_w = 0; rdata_w = {32'd0, $urandom}; stalled = 1; cur.lat--;
                end else begin
                    rvalid_w = 1; rdata_w = {32'd0, cur.data};
                end
            end else begin
                rvalid_w = ($urandom_range(0, 3) == 0); rdata_w = {32'd0, $urandom};
            end
            sq.push_back(stalled);
            if (cur.vld && !stalled) begin
                cq.push_back('{cur.rw && cur.rd != 5'd0, cur.rd, exp_result(cur)});
                exp_cnt++;
            end
            nx.vld = tail ? 1'b0 : ($urandom_range(0, 4) != 0);
            nx.rw  = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            nx.src = (r < 4) ? 3'd1 : 3'($urandom_range(0, 7));
            nx.f3  = 3'($urandom_range(0, 7));
            nx.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            nx.alu = $urandom; nx.pc4 = $urandom; nx.imm = $urandom; nx.csr = $urandom;
            nx.data = $urandom;
            nx.lat = int'($urandom_range(0, 3));
            v_m = nx.vld; rw_m = nx.rw; src_m = nx.src; f3_m = nx.f3; rd_m = nx.rd;
            alu_m = {32'd0, nx.alu}; pc4_m = {32'd0, nx.pc4};
            imm_m = {32'd0, nx.imm}; csr_m = {32'd0, nx.csr};
            stall_w = tail ? 1'b0 : ($urandom_range(0, 7) == 0);
            flush_w = tail ? 1'b0 : ($urandom_range(0, 7) == 0);
            if (!stalled && !stall_w) begin
                if (flush_w) cur.vld = 0;
                else cur = nx;
            end
            step;
        end
        sq.push_back(1'b0);
        @(negedge clk);
        #1 mon_en = 1'b0;
        chk("commit_queue_drained", cq.size(), 0);
        chk("stall_queue_drained", sq.size(), 0);
        chk("final_instret", iret32, exp_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
